chu_mmio_master: RTL and testbench
==================================

CHU_MMIO_MASTER -- requirements
Module: chu_mmio_master

Interface
REQ-001 Parameter RD_WAIT, default 0: extra read wait cycles, range 0..15.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-006 req_wr  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  21  FPRO address: [10:5] slot, [4:0] register.
REQ-008 req_wr_data  input  32  write data.
REQ-009 resp_valid  output  1  transaction complete; held until accepted.
REQ-010 resp_ready  input  1  response accepted when resp_valid && resp_ready.
REQ-011 resp_data  output  32  captured read data; 0 for writes.
REQ-012 mmio_cs  output  1  FPRO bus chip select.
REQ-013 mmio_wr  output  1  FPRO write strobe.
REQ-014 mmio_rd  output  1  FPRO read strobe.
REQ-015 mmio_addr  output  21  FPRO address.
REQ-016 mmio_wr_data  output  32  FPRO write data.
REQ-017 mmio_rd_data  input  32  FPRO read data, combinational from slot, valid while mmio_cs high.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 On accept, the block SHALL latch req_wr, req_addr and req_wr_data, then go IDLE->ISSUE.
REQ-021 In ISSUE (exactly one cycle):
- mmio_cs = 1.
- mmio_wr = latched wr.
- mmio_rd = !latched wr.
- mmio_addr and mmio_wr_data driven from the latches.
REQ-022 All mmio_* outputs SHALL be registered and glitch-free; mmio_wr/mmio_rd SHALL never be high while mmio_cs is low.
REQ-023 Write path: ISSUE->RESP; resp_data = 0.
REQ-024 Read with RD_WAIT=0: mmio_rd_data SHALL be sampled at the rising edge ending ISSUE; then ISSUE->RESP.
REQ-025 Read with RD_WAIT=N>0: ISSUE->WAIT for N cycles with these outputs:
- mmio_cs = 1, mmio_rd = 0, mmio_addr held.
- A 4-bit down-counter loaded with N-1 on entry.
- Sampling at the edge where the counter is 0; then WAIT->RESP.
REQ-026 In WAIT and RESP, mmio_wr = 0 and mmio_rd = 0; in RESP and IDLE, mmio_cs = 0.
REQ-027 resp_valid SHALL be 1 only in RESP, and resp_data SHALL stay stable there.
REQ-028 RESP->IDLE on resp_ready; if resp_ready is already high on RESP entry, RESP lasts one cycle.
REQ-029 Latencies:
- Write: accept edge T, strobe in cycle T+1, resp_valid in cycle T+2.
- Read: resp_valid in cycle T+2+RD_WAIT.
- Minimum spacing: one transaction per 3 cycles (RD_WAIT=0, resp_ready=1).
REQ-030 A request arriving while not IDLE SHALL NOT be accepted and SHALL NOT alter latched values.

Reset
REQ-031 While rst is low:
- State = IDLE, req_ready = 0.
- resp_valid = 0, resp_data = 0.
- mmio_cs/wr/rd = 0, mmio_addr = 0, mmio_wr_data = 0, wait counter = 0.
REQ-032 req_ready SHALL rise in the first cycle after rst deasserts.
REQ-033 Reset mid-transaction SHALL abort it with no response, and all strobes SHALL drop immediately (asynchronously).

Structure
REQ-034 Package chu_mmio_pkg SHALL hold:
- Constants MMIO_ADDR_W=21, MMIO_DATA_W=32, SLOT_W=6, REG_W=5.
- The state enum typedef.
REQ-035 Single module, no sub-module; the wait counter is inline.

Verification
REQ-036 Write: req addr=0x000C3, data=0xDEADBEEF, then check:
- One cycle with cs=1, wr=1, rd=0, addr=0x000C3, wr_data=0xDEADBEEF.
- resp_valid next cycle with resp_data=0.
REQ-037 Read with RD_WAIT=0 and the slot model returning 0x12345678 at addr 0x00041 -> resp_data=0x12345678, resp_valid at T+2, rd high exactly one cycle.
REQ-038 Read with RD_WAIT=2:
- cs high 3 cycles, rd high only in the first.
- Data changing to 0xA5A5A5A5 in the last wait cycle -> resp_data=0xA5A5A5A5, resp_valid at T+4.
REQ-039 Backpressure: resp_ready low 5 cycles -> resp_valid and resp_data held, req_ready=0, and a concurrent req_valid is not accepted.
REQ-040 Back-to-back: 4 alternating write/read requests with resp_ready=1 -> accepted every 3 cycles, correct strobes and data per transaction.
REQ-041 Reset mid-op: rst low during ISSUE of a write -> cs/wr drop in the same cycle, no resp_valid, and req_ready=1 one cycle after release.

Source files
------------

// File: rtl/chu_mmio_pkg.sv
// Shared constants and FSM state type for the FPRO MMIO bus master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chu_mmio_pkg;

  localparam int MMIO_ADDR_W = 21;
  localparam int MMIO_DATA_W = 32;
  localparam int SLOT_W      = 6;   // address bits [10:5] pick the slot
  localparam int REG_W       = 5;   // address bits [4:0] pick the register in a slot
  localparam int WAIT_CNT_W  = 4;   // enough for RD_WAIT up to 15

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/chu_mmio_master.sv
// Bridges a valid/ready request/response channel onto the FPRO MMIO bus, one transaction at a time.
// Latency: write response 2 cycles after accept; read response 2+RD_WAIT cycles after accept.
// Backpressure: req_ready only in IDLE; the response is held in RESP until resp_ready.
module chu_mmio_master
  import chu_mmio_pkg::*;
#(
  parameter int RD_WAIT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [MMIO_ADDR_W-1:0] req_addr,
  input  logic [MMIO_DATA_W-1:0] req_wr_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [MMIO_DATA_W-1:0] resp_data,
  output logic                   mmio_cs,
  output logic                   mmio_wr,
  output logic                   mmio_rd,
  output logic [MMIO_ADDR_W-1:0] mmio_addr,
  output logic [MMIO_DATA_W-1:0] mmio_wr_data,
  input  logic [MMIO_DATA_W-1:0] mmio_rd_data
);

  // The wait counter is loaded with N-1 so that it reads 0 in the last of N wait cycles.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : '0;

  state_e                 state_q, state_d;
  logic                   wr_q, wr_d;
  logic [MMIO_ADDR_W-1:0] mmio_addr_q, mmio_addr_d;
  logic [MMIO_DATA_W-1:0] mmio_wr_data_q, mmio_wr_data_d;
  logic                   mmio_cs_q, mmio_cs_d;
  logic                   mmio_wr_q, mmio_wr_d;
  logic                   mmio_rd_q, mmio_rd_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [MMIO_DATA_W-1:0] resp_data_q, resp_data_d;
  logic                   req_ready_q, req_ready_d;

  // Next-state logic; bus strobes are decoded from the next state so they leave flops cleanly.
  always_comb begin
    state_d        = state_q;
    wr_d           = wr_q;
    mmio_addr_d    = mmio_addr_q;
    mmio_wr_data_d = mmio_wr_data_q;
    cnt_d          = cnt_q;
    resp_data_d    = resp_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d           = req_wr;
          mmio_addr_d    = req_addr;
          mmio_wr_data_d = req_wr_data;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          resp_data_d = '0;
          state_d     = RESP;
        end else if (RD_WAIT == 0) begin
          resp_data_d = mmio_rd_data;
          state_d     = RESP;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          resp_data_d = mmio_rd_data;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Chip select spans ISSUE and WAIT; the strobe is a single ISSUE cycle.
    mmio_cs_d   = (state_d == ISSUE) || (state_d == WAIT);
    mmio_wr_d   = (state_d == ISSUE) && wr_d;
    mmio_rd_d   = (state_d == ISSUE) && !wr_d;
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset clears everything, so strobes drop asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      wr_q           <= 1'b0;
      mmio_addr_q    <= '0;
      mmio_wr_data_q <= '0;
      mmio_cs_q      <= 1'b0;
      mmio_wr_q      <= 1'b0;
      mmio_rd_q      <= 1'b0;
      cnt_q          <= '0;
      resp_data_q    <= '0;
      req_ready_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_q           <= wr_d;
      mmio_addr_q    <= mmio_addr_d;
      mmio_wr_data_q <= mmio_wr_data_d;
      mmio_cs_q      <= mmio_cs_d;
      mmio_wr_q      <= mmio_wr_d;
      mmio_rd_q      <= mmio_rd_d;
      cnt_q          <= cnt_d;
      resp_data_q    <= resp_data_d;
      req_ready_q    <= req_ready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_data    = resp_data_q;
  assign mmio_cs      = mmio_cs_q;
  assign mmio_wr      = mmio_wr_q;
  assign mmio_rd      = mmio_rd_q;
  assign mmio_addr    = mmio_addr_q;
  assign mmio_wr_data = mmio_wr_data_q;

endmodule

// File: tb/tb_chu_mmio_master.sv
// Bench for chu_mmio_master with RD_WAIT=0 and RD_WAIT=2 instances against a slot memory model.
// Latency: expected response cycle is derived from the accept cycle and the read wait count.
// Backpressure: resp_ready is held low or randomised; response hold and request blocking are checked.
module tb_chu_mmio_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wr, resp_ready;
  logic [20:0] req_addr;
  logic [31:0] req_wr_data;
  int          sel;
  logic        ovr_en;
  logic [31:0] ovr_val;
  bit          rand_bp;

  logic        rv     [2];
  logic        rr     [2];
  logic        rsp_v  [2];
  logic [31:0] rsp_d  [2];
  logic        cs     [2];
  logic        wr     [2];
  logic        rd     [2];
  logic [20:0] maddr  [2];
  logic [31:0] mwd    [2];
  logic [31:0] mrd    [2];

  logic [31:0] slot_mem [2048];
  logic        mem_init = 1'b0;
  logic [31:0] ref_mem  [int];
  int          cyc = 0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    int          first;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign rv[0] = req_valid && (sel == 0);
  assign rv[1] = req_valid && (sel == 1);

  chu_mmio_master #(.RD_WAIT(0)) dut0 (
    .clk(clk), .rst(rst_n),
    .req_valid(rv[0]), .req_ready(rr[0]), .req_wr(req_wr), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .resp_valid(rsp_v[0]), .resp_ready(resp_ready),
    .resp_data(rsp_d[0]), .mmio_cs(cs[0]), .mmio_wr(wr[0]), .mmio_rd(rd[0]),
    .mmio_addr(maddr[0]), .mmio_wr_data(mwd[0]), .mmio_rd_data(mrd[0])
  );

  chu_mmio_master #(.RD_WAIT(2)) dut2 (
    .clk(clk), .rst(rst_n),
    .req_valid(rv[1]), .req_ready(rr[1]), .req_wr(req_wr), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .resp_valid(rsp_v[1]), .resp_ready(resp_ready),
    .resp_data(rsp_d[1]), .mmio_cs(cs[1]), .mmio_wr(wr[1]), .mmio_rd(rd[1]),
    .mmio_addr(maddr[1]), .mmio_wr_data(mwd[1]), .mmio_rd_data(mrd[1])
  );

  function automatic logic [31:0] init_val(input logic [10:0] a);
    if (a == 11'h041) return 32'h12345678;
    if (a == 11'h0A4) return 32'h11111111;
    return (32'(a) * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [10:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter used to timestamp accepts and responses.
  always @(posedge clk) cyc <= cyc + 1;

  // Slot model: combinational read data while selected; optional override for late data changes.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mrd[i] = '0;
      if (cs[i]) mrd[i] = ovr_en ? ovr_val : slot_mem[maddr[i][10:0]];
    end
  end

  // Slot model: preload once, then apply write strobes at the clock edge.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 2048; i++) slot_mem[i] <= init_val(11'(i));
      mem_init <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (cs[i] && wr[i]) slot_mem[maddr[i][10:0]] <= mwd[i];
    end
  end

  logic        s_rr, s_v, s_cs, s_wr, s_rd;
  logic [31:0] s_d, s_wd;
  logic [20:0] s_addr;
  assign s_rr   = rr[sel];
  assign s_v    = rsp_v[sel];
  assign s_d    = rsp_d[sel];
  assign s_cs   = cs[sel];
  assign s_wr   = wr[sel];
  assign s_rd   = rd[sel];
  assign s_addr = maddr[sel];
  assign s_wd   = mwd[sel];

  int          cs_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  bit          prev_vld = 0;
  logic [31:0] held;
  exp_t        mon_e;

  // Monitor: accumulates bus activity per transaction and checks each response against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      cs_cnt = 0; wr_cnt = 0; rd_cnt = 0; prev_vld = 0;
    end else begin
      chk("strobe_needs_cs", 32'((s_wr || s_rd) && !s_cs), 32'd0);
      if (s_cs && exp_q.size() == 0) chk("cs_without_request", 32'(s_cs), 32'd0);
      if (s_cs) cs_cnt++;
      if ((s_wr || s_rd) && exp_q.size() != 0) begin
        chk("strobe_addr", 32'(s_addr), 32'(exp_q[0].addr));
        if (s_wr) chk("strobe_wr_data", s_wd, exp_q[0].wdata);
      end
      if (s_wr) wr_cnt++;
      if (s_rd) rd_cnt++;
      if (s_v) begin
        chk("req_ready_in_resp", 32'(s_rr), 32'd0);
        if (!prev_vld) begin
          if (exp_q.size() == 0) chk("resp_without_request", 32'(s_v), 32'd0);
          else begin
            chk("resp_latency", 32'(cyc), 32'(exp_q[0].first));
            chk("cs_cycles", 32'(cs_cnt), exp_q[0].wr ? 32'd1 : 32'(1 + (sel == 1 ? 2 : 0)));
            chk("wr_cycles", 32'(wr_cnt), exp_q[0].wr ? 32'd1 : 32'd0);
            chk("rd_cycles", 32'(rd_cnt), exp_q[0].wr ? 32'd0 : 32'd1);
          end
          held = s_d;
        end else begin
          chk("resp_data_hold", s_d, held);
        end
        if (resp_ready && exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("resp_data", s_d, mon_e.data);
          if (mon_e.wr) ref_mem[int'(mon_e.addr[10:0])] = mon_e.wdata;
          cs_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        end
      end
      prev_vld = s_v && !resp_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) resp_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one request, wait for acceptance, and push the expected response.
  task automatic issue(input logic w, input logic [20:0] a, input logic [31:0] d,
                       input bit use_exp, input logic [31:0] exp_d, output int acc);
    int   n;
    logic rdy;
    exp_t e;
    req_valid = 1'b1; req_wr = w; req_addr = a; req_wr_data = d;
    n = 0;
    rdy = 1'b0;
    while (n < 200 && !rdy) begin
      rdy = s_rr;
      tick();
      n++;
    end
    req_valid = 1'b0;
    acc = cyc;
    if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
    else begin
      e.wr    = w;
      e.addr  = a;
      e.wdata = d;
      e.data  = w ? 32'd0 : (use_exp ? exp_d : ref_rd(a[10:0]));
      e.first = acc + 1 + ((w || sel == 0) ? 0 : 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic rand_run(input int count);
    int acc;
    rand_bp = 1;
    for (int i = 0; i < count; i++) begin
      issue(1'($urandom_range(0, 1)),
            {10'($urandom), 11'($urandom_range(0, 15))}, $urandom, 0, 32'd0, acc);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_bp = 0;
    resp_ready = 1'b1;
    drain();
  endtask

  initial begin
    int acc, prev;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wr_data = '0;
    resp_ready = 1'b1; sel = 0; ovr_en = 1'b0; ovr_val = '0; rand_bp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 32'(rr[i]), 32'd0);
      chk("rst_resp_valid", 32'(rsp_v[i]), 32'd0);
      chk("rst_resp_data", rsp_d[i], 32'd0);
      chk("rst_strobes", {29'd0, cs[i], wr[i], rd[i]}, 32'd0);
      chk("rst_mmio_addr", 32'(maddr[i]), 32'd0);
      chk("rst_mmio_wr_data", mwd[i], 32'd0);
    end
    #3 rst_n = 1'b1;
    tick();
    chk("ready_after_reset_0", 32'(rr[0]), 32'd1);
    chk("ready_after_reset_2", 32'(rr[1]), 32'd1);

    // Directed write, read of a preset register, and readback of the written one.
    issue(1'b1, 21'h000C3, 32'hDEADBEEF, 0, 32'd0, acc); drain();
    issue(1'b0, 21'h00041, 32'd0, 0, 32'd0, acc); drain();
    issue(1'b0, 21'h000C3, 32'd0, 0, 32'd0, acc); drain();

    // Back-to-back alternating write/read with resp_ready held high.
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'(i % 2 == 0), 21'h00100 + 21'(i / 2), $urandom, 0, 32'd0, acc);
      if (i > 0) chk("b2b_spacing", 32'(acc - prev), 32'd3);
      prev = acc;
    end
    drain();

    // Response backpressure with a competing request held on the input.
    resp_ready = 1'b0;
    issue(1'b0, 21'h00041, 32'd0, 0, 32'd0, acc);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 21'h001FF; req_wr_data = $urandom;
    tick();
    repeat (5) tick();
    chk("bp_resp_valid_held", 32'(s_v), 32'd1);
    chk("bp_latch_held", 32'(s_addr), 32'h41);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    drain();
    repeat (4) tick();

    rand_run(40);

    // Reset during the ISSUE cycle of a write aborts it.
    issue(1'b1, 21'h00077, 32'hCAFEF00D, 0, 32'd0, acc);
    chk("abort_cs_before", 32'(s_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_async", 32'(s_cs), 32'd0);
    chk("abort_wr_async", 32'(s_wr), 32'd0);
    exp_q.delete();
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    chk("abort_ready_after_release", 32'(s_rr), 32'd1);
    repeat (4) tick();
    issue(1'b0, 21'h00077, 32'd0, 0, 32'd0, acc); drain();

    // RD_WAIT=2 instance: read data changes only in the last wait cycle.
    sel = 1;
    tick();
    issue(1'b0, 21'h000A4, 32'd0, 1, 32'hA5A5A5A5, acc);
    tick();
    tick();
    ovr_val = 32'hA5A5A5A5; ovr_en = 1'b1;
    tick();
    ovr_en = 1'b0;
    drain();
    issue(1'b1, 21'h000C3, 32'h0BADF00D, 0, 32'd0, acc); drain();
    issue(1'b0, 21'h000C3, 32'd0, 0, 32'd0, acc); drain();

    rand_run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
